aes_enc_round_ctrl: RTL and testbench



---
 rtl/aes_pkg.sv | 81 ++++++++
 rtl/aes_key_step.sv | 34 +++
 rtl/aes_enc_round_ctrl.sv | 145 ++++++++++++++
 tb/tb_aes_enc_round_ctrl.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES-128 types, constants and combinational round-stage functions.
package aes_pkg;

    localparam int unsigned AES_NR    = 10;
    localparam logic [7:0]  RCON_INIT = 8'h01;

    typedef logic [127:0] aes_block_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ROUND = 2'd1,
        ST_FINAL = 2'd2,
        ST_DONE  = 2'd3
    } aes_state_e;

    // Forward S-box, indexed by input byte value.
    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[b];
    endfunction

    // Byte i lives at [127-8i -: 8]; state[r][c] is byte 4c+r.
    function automatic aes_block_t sub_bytes(input aes_block_t s);
        aes_block_t o;
        for (int i = 0; i < 16; i++) begin
            o[127-8*i -: 8] = sbox(s[127-8*i -: 8]);
        end
        return o;
    endfunction

    // Row r rotates left by r columns.
    function automatic aes_block_t shift_rows(input aes_block_t s);
        aes_block_t o;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+r)%4)+r) -: 8];
            end
        end
        return o;
    endfunction

    function automatic aes_block_t mix_columns(input aes_block_t s);
        aes_block_t o;
        logic [7:0] a0, a1, a2, a3;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8];
            a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8];
            a3 = s[103-32*c -: 8];
            o[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            o[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            o[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            o[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
        return o;
    endfunction

endpackage

// File: rtl/aes_key_step.sv
// One on-the-fly AES-128 key-expansion step: four words in, next four words out.
module aes_key_step
    import aes_pkg::*;
(
    input  logic [127:0] rk,
    input  logic [7:0]   rcon,
    output logic [127:0] next_rk
);

    logic [31:0] w_rot;
    logic [31:0] w_sub;
    logic [31:0] w_t;
    logic [31:0] w_w0;
    logic [31:0] w_w1;
    logic [31:0] w_w2;
    logic [31:0] w_w3;

    // RotWord on the last word.
    assign w_rot = {rk[23:0], rk[31:24]};

    // SubWord: four S-box lookups.
    for (genvar gi = 0; gi < 4; gi++) begin : g_sbox
        assign w_sub[31-8*gi -: 8] = sbox(w_rot[31-8*gi -: 8]);
    end

    // Chain the XORs across the four words.
    assign w_t     = w_sub ^ {rcon, 24'h0};
    assign w_w0    = rk[127:96] ^ w_t;
    assign w_w1    = rk[95:64]  ^ w_w0;
    assign w_w2    = rk[63:32]  ^ w_w1;
    assign w_w3    = rk[31:0]   ^ w_w2;
    assign next_rk = {w_w0, w_w1, w_w2, w_w3};

endmodule

// File: rtl/aes_enc_round_ctrl.sv
// Iterative AES-128 encryption controller: one round per clock.
// Build option AES_BACK_TO_BACK_EN: accept a new block in the same cycle the
// finished ciphertext is handed off, skipping the IDLE bubble.
module aes_enc_round_ctrl
    import aes_pkg::*;
#(
    parameter int unsigned NR    = 10,
    parameter int unsigned CNT_W = 4
)(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [127:0]     data_in,
    input  logic [127:0]     key_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [127:0]     data_out,
    output logic             busy,
    output logic [CNT_W-1:0] round_idx
);

    if (NR != AES_NR) begin : g_bad_nr
        $error("aes_enc_round_ctrl: only NR=10 (AES-128) is supported");
    end

    aes_state_e       r_state, w_state_nxt;
    aes_block_t       r_st, w_st_nxt;
    aes_block_t       r_rk, w_rk_nxt;
    aes_block_t       r_dout, w_dout_nxt;
    logic [7:0]       r_rcon, w_rcon_nxt;
    logic [CNT_W-1:0] r_round, w_round_nxt;
    logic             r_out_valid, w_out_valid_nxt;
    logic             r_in_ready, w_in_ready_nxt;
    logic             r_busy, w_busy_nxt;

    aes_block_t       w_nk;
    aes_block_t       w_sr;
    aes_block_t       w_mc;
    logic             w_accept;

    aes_key_step u_key_step (
        .rk      (r_rk),
        .rcon    (r_rcon),
        .next_rk (w_nk)
    );

    // Round datapath: SubBytes -> ShiftRows -> MixColumns.
    assign w_sr = shift_rows(sub_bytes(r_st));
    assign w_mc = mix_columns(w_sr);

`ifdef AES_BACK_TO_BACK_EN
    assign in_ready = r_in_ready | ((r_state == ST_DONE) & out_ready);
`else
    assign in_ready = r_in_ready;
`endif
    assign w_accept  = in_valid & in_ready;
    assign out_valid = r_out_valid;
    assign data_out  = r_dout;
    assign busy      = r_busy;
    assign round_idx = r_round;

    // Next-state and next-register values; acceptance overrides the DONE hand-off.
    always_comb begin
        w_state_nxt     = r_state;
        w_st_nxt        = r_st;
        w_rk_nxt        = r_rk;
        w_rcon_nxt      = r_rcon;
        w_round_nxt     = r_round;
        w_dout_nxt      = r_dout;
        w_out_valid_nxt = r_out_valid;
        w_in_ready_nxt  = r_in_ready;
        w_busy_nxt      = r_busy;

        case (r_state)
            ST_IDLE: begin
            end
            ST_ROUND: begin
                w_st_nxt    = w_mc ^ w_nk;
                w_rk_nxt    = w_nk;
                w_rcon_nxt  = xtime(r_rcon);
                w_round_nxt = r_round + CNT_W'(1);
                if (r_round == CNT_W'(AES_NR - 1)) begin
                    w_state_nxt = ST_FINAL;
                end
            end
            ST_FINAL: begin
                w_st_nxt        = w_sr ^ w_nk;
                w_rk_nxt        = w_nk;
                w_rcon_nxt      = xtime(r_rcon);
                w_dout_nxt      = w_sr ^ w_nk;
                w_out_valid_nxt = 1'b1;
                w_state_nxt     = ST_DONE;
            end
            ST_DONE: begin
                if (out_ready) begin
                    w_out_valid_nxt = 1'b0;
                    w_round_nxt     = '0;
                    w_in_ready_nxt  = 1'b1;
                    w_busy_nxt      = 1'b0;
                    w_state_nxt     = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        if (w_accept) begin
            w_st_nxt       = data_in ^ key_in;
            w_rk_nxt       = key_in;
            w_rcon_nxt     = RCON_INIT;
            w_round_nxt    = CNT_W'(1);
            w_in_ready_nxt = 1'b0;
            w_busy_nxt     = 1'b1;
            w_state_nxt    = ST_ROUND;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_st        <= '0;
            r_rk        <= '0;
            r_rcon      <= '0;
            r_round     <= '0;
            r_dout      <= '0;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_st        <= w_st_nxt;
            r_rk        <= w_rk_nxt;
            r_rcon      <= w_rcon_nxt;
            r_round     <= w_round_nxt;
            r_dout      <= w_dout_nxt;
            r_out_valid <= w_out_valid_nxt;
            r_in_ready  <= w_in_ready_nxt;
            r_busy      <= w_busy_nxt;
        end
    end

endmodule

// File: tb/tb_aes_enc_round_ctrl.sv
// Directed bench for aes_enc_round_ctrl using the FIPS-197 vectors.
module tb_aes_enc_round_ctrl;

    localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

`ifdef AES_BACK_TO_BACK_EN
    localparam int  B2B_GAP      = 11;
    localparam logic RDY_IN_DONE = 1'b1;
`else
    localparam int  B2B_GAP      = 12;
    localparam logic RDY_IN_DONE = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] data_in;
    logic [127:0] key_in;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] data_out;
    logic         busy;
    logic [3:0]   round_idx;

    int n_total = 0;
    int n_bad   = 0;
    int cyc     = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    aes_enc_round_ctrl #(.NR(10), .CNT_W(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .data_in   (data_in),
        .key_in    (key_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .data_out  (data_out),
        .busy      (busy),
        .round_idx (round_idx)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_total++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_out(input int budget, output int t_seen);
        bit got = 1'b0;
        t_seen = -1;
        for (int i = 0; i < budget && !got; i++) begin
            step();
            if (out_valid === 1'b1) begin
                got    = 1'b1;
                t_seen = cyc;
            end
        end
        chk("out_valid within budget", 128'(got), 128'(1));
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, " in_ready"},  128'(in_ready),  128'(1));
        chk({tag, " out_valid"}, 128'(out_valid), 128'(0));
        chk({tag, " busy"},      128'(busy),      128'(0));
        chk({tag, " round_idx"}, 128'(round_idx), 128'(0));
        chk({tag, " data_out"},  data_out,        128'(0));
    endtask

    initial begin
        int t1;
        int t2;
        bit got;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        data_in   = '0;
        key_in    = '0;
        #12;
        chk_reset_outputs("reset");
        rst_n = 1'b1;
        step();

        // App. B with exact latency, input churn after acceptance, then a 20-cycle stall.
        data_in  = PT_B;
        key_in   = KEY_B;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        chk("B accept round_idx", 128'(round_idx), 128'(1));
        chk("B accept in_ready",  128'(in_ready),  128'(0));
        chk("B accept busy",      128'(busy),      128'(1));
        for (int k = 1; k <= 9; k++) begin
            data_in = {4{$urandom}};
            key_in  = {4{$urandom}};
            step();
            chk("B round_idx", 128'(round_idx), 128'(k + 1));
            chk("B early out_valid", 128'(out_valid), 128'(0));
        end
        data_in = {4{$urandom}};
        key_in  = {4{$urandom}};
        step();
        chk("B out_valid at edge 10", 128'(out_valid), 128'(1));
        chk("B ciphertext", data_out, CT_B);

        for (int k = 0; k < 20; k++) begin
            in_valid = (k == 5);
            data_in  = PT_C;
            key_in   = KEY_C;
            step();
            chk("stall out_valid", 128'(out_valid), 128'(1));
            chk("stall data_out",  data_out,        CT_B);
            chk("stall in_ready",  128'(in_ready),  128'(0));
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        chk("handoff out_valid", 128'(out_valid), 128'(0));
        chk("handoff round_idx", 128'(round_idx), 128'(0));
        chk("handoff busy",      128'(busy),      128'(0));
        chk("handoff in_ready",  128'(in_ready),  128'(1));

        // App. C.1 with round-by-round index check.
        data_in  = PT_C;
        key_in   = KEY_C;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            chk("C round_idx", 128'(round_idx), 128'(k));
            step();
        end
        chk("C out_valid", 128'(out_valid), 128'(1));
        chk("C ciphertext", data_out, CT_C);
        step();
        chk("C handoff out_valid", 128'(out_valid), 128'(0));

        // Reset in round 5, then a clean App. B run.
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 12 && !got; i++) begin
            if (round_idx == 4'd5) got = 1'b1;
            else step();
        end
        chk("reached round 5", 128'(got), 128'(1));
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("midop reset");
        step();
        step();
        rst_n    = 1'b1;
        data_in  = PT_B;
        key_in   = KEY_B;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        wait_out(15, t1);
        chk("post-reset ciphertext", data_out, CT_B);
        step();

        // Two blocks streamed with in_valid held and out_ready high.
        data_in  = PT_B;
        key_in   = KEY_B;
        in_valid = 1'b1;
        step();
        data_in = PT_C;
        key_in  = KEY_C;
        wait_out(15, t1);
        chk("stream first ciphertext", data_out, CT_B);
        chk("stream in_ready in DONE", 128'(in_ready), 128'(RDY_IN_DONE));
        got = 1'b0;
        for (int i = 0; i < 4 && !got; i++) begin
            step();
            if (round_idx == 4'd1) got = 1'b1;
        end
        chk("stream second accept", 128'(got), 128'(1));
        in_valid = 1'b0;
        wait_out(15, t2);
        chk("stream second ciphertext", data_out, CT_C);
        chk("stream output spacing", 128'(t2 - t1), 128'(B2B_GAP));
        step();
        chk("stream final handoff", 128'(out_valid), 128'(0));

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
